// File: rtl/multicycle_control_fsm.sv
// Control unit for the multi-cycle RV32I core: Moore sequencer, ALU/immediate decoders,
// plus a retired-instruction counter and a sticky illegal-opcode flag for debug.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     cur, nxt;
  logic [1:0] alu_op;
  logic       pc_write, mem_write, ir_write, reg_write;
  logic       bad_op, done;

  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt    = S_FETCH;
    bad_op = 1'b0;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECUTER;
          OP_I:         nxt = S_EXECUTEI;
          OP_BEQ:       nxt = S_BEQ;
          OP_JAL:       nxt = S_JAL;
          default: begin
            nxt    = S_FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:   nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = S_MEMWB;
      S_EXECUTER: nxt = S_ALUWB;
      S_EXECUTEI: nxt = S_ALUWB;
      S_JAL:      nxt = S_ALUWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    AdrSrc    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    reg_write = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op   = 2'b01;
        pc_write = Zero;  // branch taken is the one input-dependent output
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural enables are held off while reset is asserted.
  assign PCWrite  = pc_write  & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Every completing state returns to FETCH, so leaving one of them retires an instruction.
  assign done = (cur == S_MEMWB) || (cur == S_MEMWRITE) || (cur == S_ALUWB) || (cur == S_BEQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (bad_op) illegal <= 1'b1;
      if (done)   retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle control word;
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_control_fsm;
  localparam int CW = 4;  // small counter so wraparound is reached quickly
  localparam int W  = 4 + 1 + 1 + 1 + 1 + 2 + 3 + 2 + 2 + 2 + 1 + 1 + CW;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, Zero = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcB, ALUSrcA, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic [CW-1:0] retired;

  multicycle_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [W-1:0] sb[$];
  logic mon_on = 1'b0;
  int m_ret = 0;
  logic m_ill = 1'b0;

  function automatic logic [W-1:0] dut_word();
    return {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
            ALUSrcB, ALUSrcA, ImmSrc, RegWrite, illegal, retired};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (state got %0d want %0d) t=%0t",
               name, act, exp, act[W-1 -: 4], exp[W-1 -: 4], $time);
    end
  endtask

  task automatic check1(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (sb.size() == 0) check("sb_empty", dut_word(), '1);
      else check("cycle", dut_word(), sb.pop_front());
    end
  end

  // Expected control word for one cycle of an instruction, from the per-step table.
  function automatic logic [W-1:0] expect_word(input int s, input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb_, imm;
    logic [2:0] alu;
    pcw = (s == 0) || (s == 10) || (s == 9 && z);
    adr = (s == 3) || (s == 5);
    mw  = (s == 5);
    irw = (s == 0);
    rw  = (s == 4) || (s == 8);
    rs  = (s == 0) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
    sa  = (s == 1 || s == 10) ? 2'b01 : (s == 2 || s == 6 || s == 7 || s == 9) ? 2'b10 : 2'b00;
    sb_ = (s == 0 || s == 10) ? 2'b10 : (s == 1 || s == 2 || s == 7) ? 2'b01 : 2'b00;
    alu = 3'b000;                                   // add
    if (s == 9) alu = 3'b001;                       // beq compares by subtraction
    else if (s == 6 || s == 7) begin
      case (f3)
        3'b000:  alu = (o == RT && f7) ? 3'b001 : 3'b000;  // sub only for R-type
        3'b010:  alu = 3'b101;
        3'b110:  alu = 3'b011;
        3'b111:  alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end
    imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    return {4'(s), pcw, adr, mw, irw, rs, alu, sb_, sa, imm, rw, m_ill, CW'(m_ret)};
  endfunction

  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int seq[$];
    bool_valid: begin end
    case (o)
      LW: seq = '{0, 1, 2, 3, 4};
      SW: seq = '{0, 1, 2, 5};
      RT: seq = '{0, 1, 6, 8};
      IT: seq = '{0, 1, 7, 8};
      BQ: seq = '{0, 1, 9};
      JL: seq = '{0, 1, 10, 8};
      default: seq = '{0, 1};
    endcase
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    foreach (seq[i]) sb.push_back(expect_word(seq[i], o, f3, f7, z));
    if (seq.size() == 2) m_ill = 1'b1;
    else m_ret = (m_ret + 1) % (1 << CW);
    mon_on = 1'b1;
    repeat (seq.size()) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_rand();
    logic [6:0] ops[7];
    logic [6:0] bads[5];
    logic [2:0] f3s[5];
    int k;
    ops  = '{LW, SW, RT, IT, BQ, JL, 7'b0};
    bads = '{7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000, 7'b1111111};
    f3s  = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
    k = $urandom_range(0, 7);
    issue((k >= 6) ? bads[$urandom_range(0, 4)] : ops[k], f3s[$urandom_range(0, 4)],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #2;
    check1("reset_state", int'(state), 0);
    check1("reset_irwrite", int'(IRWrite), 0);
    check1("reset_pcwrite", int'(PCWrite), 0);
    check1("reset_retired", int'(retired), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(LW, 3'b010, 1'b0, 1'b0);
    issue(SW, 3'b010, 1'b0, 1'b0);
    issue(RT, 3'b000, 1'b0, 1'b0);
    issue(RT, 3'b000, 1'b1, 1'b0);   // sub
    issue(IT, 3'b000, 1'b1, 1'b0);   // addi, not sub
    issue(RT, 3'b110, 1'b0, 1'b0);
    issue(IT, 3'b010, 1'b0, 1'b0);
    issue(RT, 3'b111, 1'b0, 1'b1);
    issue(BQ, 3'b000, 1'b0, 1'b1);
    issue(BQ, 3'b000, 1'b0, 1'b0);
    issue(JL, 3'b000, 1'b0, 1'b0);
    issue(7'b0110111, 3'b000, 1'b0, 1'b0);
    issue(LW, 3'b010, 1'b0, 1'b0);
    repeat (40) issue_rand();

    // Asynchronous reset in the middle of EXECUTER.
    mon_on = 1'b0;
    sb.delete();
    op = RT; funct3 = 3'b000; funct7b5 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    check1("pre_reset_executer", int'(state), 6);
    reset = 1'b1;
    #1;
    check1("async_state", int'(state), 0);
    check1("async_regwrite", int'(RegWrite), 0);
    check1("async_irwrite", int'(IRWrite), 0);
    check1("async_retired", int'(retired), 0);
    check1("async_illegal", int'(illegal), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_ret = 0; m_ill = 1'b0;
    #2;
    check1("post_reset_fetch", int'(state), 0);
    check1("post_reset_irwrite", int'(IRWrite), 1);
    check1("post_reset_pcwrite", int'(PCWrite), 1);

    repeat (60) issue_rand();
    mon_on = 1'b0;
    check1("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
